// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler for NUM_Q registered-output source FIFOs.
// Polls one enabled FIFO at a time and takes up to BURST words from it per grant.
// Each word is held on a valid/ready output port. A read that finds its FIFO
// empty ends the grant.
module fifo_rr_sched #(
   parameter int NUM_Q = 4,
   parameter int DW    = 32,
   parameter int BURST = 4,
   localparam int QW   = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_Q-1:0]    cfg_en,
   output logic [NUM_Q-1:0]    q_rd_en,
   input  logic [NUM_Q-1:0]    q_empty,
   input  logic [NUM_Q*DW-1:0] q_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-1:0]       out_data,
   output logic [QW-1:0]       out_qid
);

   localparam logic [3:0] BURST_C = 4'(BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [QW-1:0]   sel_q;
   logic [QW-1:0]   last_q;
   logic [QW-1:0]   pick;
   logic [3:0]      cnt_q;
   logic            run_q;
   logic            any_en;
   logic            hit;
   logic            cont;
   logic [DW-1:0]   q_word [NUM_Q];

   // First enabled index strictly after 'last', wrapping from NUM_Q-1 to 0.
   // If 'last' is the only enabled index, it is picked again.
   function automatic logic [QW-1:0] rr_pick(input logic [NUM_Q-1:0] en,
                                             input logic [QW-1:0]    last);
      logic [QW-1:0] res;
      logic [QW-1:0] cand;
      logic          found;
      res   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_Q; k++) begin
         cand = QW'((int'(last) + k) % NUM_Q);
         if (!found && en[cand]) begin
            res   = cand;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   for (genvar g = 0; g < NUM_Q; g++) begin : g_word
      assign q_word[g] = q_data[g*DW +: DW];
   end

   assign pick   = rr_pick(cfg_en, last_q);
   assign any_en = |cfg_en;
   // The FIFO's empty flag is only meaningful the cycle after our own read.
   assign hit    = ~q_empty[sel_q];
   // Burst continuation: issued in the handshake cycle itself, so back-to-back
   // words are two cycles apart.
   assign cont   = (state_q == OUT) && out_ready && (cnt_q < BURST_C) && cfg_en[sel_q];

   // State register; reset forces IDLE asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run_q && any_en) state_d = WAIT;
         WAIT:    state_d = hit ? OUT : IDLE;
         OUT:     if (out_ready) state_d = cont ? WAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read strobe: one-hot, only for an IDLE poll or a burst continuation.
   // run_q holds it off until a clock edge has seen reset released.
   always_comb begin
      q_rd_en = '0;
      if (state_q == IDLE && run_q && any_en) q_rd_en[pick]  = 1'b1;
      else if (cont)                          q_rd_en[sel_q] = 1'b1;
   end

   // Grant bookkeeping and the output word register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q     <= 1'b0;
         sel_q     <= '0;
         last_q    <= QW'(NUM_Q - 1);
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_qid   <= '0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (run_q && any_en) begin
                  sel_q <= pick;
                  cnt_q <= '0;
               end
            end
            WAIT: begin
               if (hit) begin
                  out_data  <= q_word[sel_q];
                  out_qid   <= sel_q;
                  out_valid <= 1'b1;
                  cnt_q     <= cnt_q + 4'd1;
               end else begin
                  last_q <= sel_q;
                  cnt_q  <= '0;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (!cont) begin
                     last_q <= sel_q;
                     cnt_q  <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched. It models four registered-output FIFOs and keeps a
// scoreboard of expected {qid, data} words. It runs a table of arbitration
// scenarios and then a few hand-written corner sequences.
module tb_fifo_rr_sched;

   logic         clk;
   logic         rst;
   logic [3:0]   cfg_en;
   logic [3:0]   q_rd_en;
   logic [3:0]   q_empty = 4'hF;
   logic [127:0] q_data  = '0;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_qid;

   logic [31:0]  mem [4][256];
   int           wr_ptr [4] = '{0, 0, 0, 0};
   int           rd_ptr [4] = '{0, 0, 0, 0};

   typedef struct packed {
      logic [1:0]  qid;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q [$];

   typedef struct {
      logic [3:0]  cfg;
      int          n [4];
      int          len;
      logic [31:0] seq;   // expected qid order, 2 bits per word, first word in LSBs
   } vec_t;
   vec_t vecs [5];

   int checks = 0;
   int errors = 0;

   fifo_rr_sched dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_en    (cfg_en),
      .q_rd_en   (q_rd_en),
      .q_empty   (q_empty),
      .q_data    (q_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_qid   (out_qid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO models: empty flag and data update only on an edge that samples rd_en.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (q_rd_en[i]) begin
            if (rd_ptr[i] < wr_ptr[i]) begin
               q_data[i*32 +: 32] <= mem[i][rd_ptr[i]];
               q_empty[i]         <= 1'b0;
               rd_ptr[i]          <= rd_ptr[i] + 1;
            end else begin
               q_data[i*32 +: 32] <= '0;
               q_empty[i]         <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] q, input logic [31:0] d);
      exp_t e;
      e.qid  = q;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic load(input int i, input logic [31:0] w);
      if (wr_ptr[i] < 256) begin
         mem[i][wr_ptr[i]] = w;
         wr_ptr[i]++;
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 4; i++) wr_ptr[i] = rd_ptr[i];
   endtask

   // Samples the end of the current cycle, where a handshake is decided.
   task automatic monitor();
      exp_t e;
      checks++;
      if ($countones(q_rd_en) > 1 || (q_rd_en & ~cfg_en) != 4'b0) begin
         errors++;
         $display("FAIL rd_en_legal: got rd_en=%b, expected one-hot within cfg_en=%b", q_rd_en, cfg_en);
      end
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_extra: got qid=%0d data=%08h, expected no word", out_qid, out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_qid !== e.qid || out_data !== e.data) begin
               errors++;
               $display("FAIL scoreboard: got qid=%0d data=%08h, expected qid=%0d data=%08h",
                        out_qid, out_data, e.qid, e.data);
            end
         end
      end
   endtask

   // Monitor at the falling edge, then return just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk(name, out_valid, 1);
   endtask

   task automatic set_vec(input int v, input logic [3:0] cfg, input int n0, input int n1,
                          input int n2, input int n3, input int len, input logic [31:0] seq);
      vecs[v].cfg  = cfg;
      vecs[v].n[0] = n0;
      vecs[v].n[1] = n1;
      vecs[v].n[2] = n2;
      vecs[v].n[3] = n3;
      vecs[v].len  = len;
      vecs[v].seq  = seq;
   endtask

   function automatic logic [31:0] vdat(input int v, input int i, input int k);
      return 32'h10 + 32'(i) + 32'(4 * k) + 32'(v * 32'h1000);
   endfunction

   task automatic run_vector(input int v);
      int         cnt [4];
      logic [1:0] q;
      rst       = 1'b0;
      out_ready = 1'b1;
      cfg_en    = vecs[v].cfg;
      flush();
      tick();
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         for (int k = 0; k < vecs[v].n[i]; k++) load(i, vdat(v, i, k));
      end
      for (int j = 0; j < vecs[v].len; j++) begin
         q = 2'(vecs[v].seq >> (2 * j));
         push_exp(q, vdat(v, int'(q), cnt[q]));
         cnt[q]++;
      end
      rst = 1'b1;
      repeat (100) tick();
      chk($sformatf("vec%0d_drain", v), 64'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   initial begin
      rst       = 1'b0;
      cfg_en    = 4'b1111;
      out_ready = 1'b1;

      // cfg, words per FIFO 0..3, word count, qid order
      set_vec(0, 4'b1111, 1, 1, 1, 1,  4, 32'h0000_00E4);  // 0,1,2,3 each ending on a miss
      set_vec(1, 4'b0001, 6, 0, 0, 0,  6, 32'h0000_0000);  // burst of 4, re-poll gives 2 more
      set_vec(2, 4'b1010, 8, 8, 8, 8, 16, 32'hFF55_FF55);  // 1x4, 3x4, 1x4, 3x4
      set_vec(3, 4'b0110, 0, 2, 5, 0,  7, 32'h0000_2AA5);  // 1,1 miss, 2x4, 1 miss, 2
      set_vec(4, 4'b1001, 1, 0, 0, 5,  6, 32'h0000_0FFC);  // 0, wrap to 3x4, 0 miss, 3

      tick();
      tick();
      chk("reset_rd_en", q_rd_en, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_data",  out_data, 0);
      chk("reset_qid",   out_qid, 0);

      cfg_en = 4'b0000;
      rst    = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_rd_en", q_rd_en, 0);
         chk("idle_valid", out_valid, 0);
      end

      rst    = 1'b0;
      cfg_en = 4'b0001;
      tick();
      rst = 1'b1;
      #1;
      chk("release_no_early_poll", q_rd_en, 0);
      tick();
      chk("release_first_poll", q_rd_en, 4'b0001);

      for (int v = 0; v < 5; v++) run_vector(v);

      // Backpressure: word held stable with no reads, continuation on ready.
      rst       = 1'b0;
      cfg_en    = 4'b0001;
      out_ready = 1'b0;
      flush();
      tick();
      for (int k = 0; k < 3; k++) begin
         load(0, 32'hB000 + 32'(k));
         push_exp(2'd0, 32'hB000 + 32'(k));
      end
      rst = 1'b1;
      wait_valid("bp_valid");
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid_hold", out_valid, 1);
         chk("bp_data_hold",  out_data, 32'hB000);
         chk("bp_qid_hold",   out_qid, 0);
         chk("bp_no_read",    q_rd_en, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_continuation", q_rd_en, 4'b0001);
      repeat (20) tick();
      chk("bp_drain", 64'(exp_q.size()), 0);
      exp_q.delete();

      // Enable dropped mid-burst: word in flight delivered, burst ends.
      rst       = 1'b0;
      cfg_en    = 4'b0011;
      out_ready = 1'b1;
      flush();
      tick();
      for (int k = 0; k < 4; k++) load(0, 32'hC000 + 32'(k));
      load(1, 32'hC100);
      push_exp(2'd0, 32'hC000);
      push_exp(2'd1, 32'hC100);
      rst = 1'b1;
      wait_valid("cfg_drop_valid");
      cfg_en = 4'b0010;
      chk("cfg_drop_qid", out_qid, 0);
      repeat (30) tick();
      chk("cfg_drop_drain", 64'(exp_q.size()), 0);
      exp_q.delete();

      // Reset while a word is held: async clear, then first poll is FIFO 0.
      rst       = 1'b0;
      cfg_en    = 4'b0001;
      out_ready = 1'b1;
      flush();
      tick();
      load(0, 32'hD000);
      push_exp(2'd0, 32'hD000);
      rst = 1'b1;
      repeat (10) tick();
      chk("rst_pre_drain", 64'(exp_q.size()), 0);
      out_ready = 1'b0;
      load(0, 32'hD001);
      wait_valid("rst_mid_valid");
      chk("rst_mid_word", out_data, 32'hD001);
      rst = 1'b0;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_data",  out_data, 0);
      chk("rst_async_rd_en", q_rd_en, 0);
      exp_q.delete();
      flush();
      cfg_en    = 4'b1111;
      out_ready = 1'b1;
      tick();
      chk("rst_hold_rd_en", q_rd_en, 0);
      rst = 1'b1;
      #1;
      chk("rst_release_no_poll", q_rd_en, 0);
      tick();
      chk("rst_first_poll_fifo0", q_rd_en, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
